// File: rtl/uart_block_assembler_if.sv
// Byte-stream in / block-out bundle for uart_block_assembler.
// slave modport is the assembler; master modport is the UART RX + AES side.
interface uart_block_assembler_if #(
  parameter int unsigned BLOCK_BYTES = 16
);
  localparam int unsigned DATA_W = 8 * BLOCK_BYTES;
  localparam int unsigned CNT_W  = $clog2(BLOCK_BYTES + 1);

  logic              rx_dv_i;
  logic [7:0]        rx_byte_i;
  logic              blk_valid_o;
  logic [DATA_W-1:0] blk_data_o;
  logic              blk_ready_i;
  logic [CNT_W-1:0]  byte_cnt_o;
  logic              overrun_o;
  logic              timeout_o;

  modport slave (
    input  rx_dv_i, rx_byte_i, blk_ready_i,
    output blk_valid_o, blk_data_o, byte_cnt_o, overrun_o, timeout_o
  );

  modport master (
    output rx_dv_i, rx_byte_i, blk_ready_i,
    input  blk_valid_o, blk_data_o, byte_cnt_o, overrun_o, timeout_o
  );
endinterface

// File: rtl/uart_block_assembler.sv
// Packs BLOCK_BYTES UART RX bytes into one block (first byte in MSBs) and
// offers it on a valid/ready handshake. Bytes arriving while a block is
// stalled are dropped and flagged on overrun_o.
// Optional feature macro: UART_ASM_TIMEOUT_EN -- discards a partial block
// after TIMEOUT_CLKS idle clocks and pulses timeout_o.
module uart_block_assembler #(
  parameter int unsigned BLOCK_BYTES  = 16,
  parameter int unsigned TIMEOUT_CLKS = 416680
) (
  input logic                  clk_i,
  input logic                  rst_i,
  uart_block_assembler_if.slave bus
);
  localparam int unsigned DATA_W = 8 * BLOCK_BYTES;
  localparam int unsigned CNT_W  = $clog2(BLOCK_BYTES + 1);

  // Parameter sanity: shift-register slicing needs at least two bytes
  if (BLOCK_BYTES < 2 || TIMEOUT_CLKS < 2) begin : g_param_check
    $error("uart_block_assembler: BLOCK_BYTES and TIMEOUT_CLKS must be >= 2");
  end

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] shifted;

`ifdef UART_ASM_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CLKS);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
  logic              expire;
`endif

  assign shifted = {data_q[DATA_W-9:0], bus.rx_byte_i};

`ifdef UART_ASM_TIMEOUT_EN
  // Idle expiry: partial block present and the last allowed idle clock
  assign expire = (cnt_q != '0) && (idle_q == IDLE_W'(TIMEOUT_CLKS - 1));
`endif

  // State register and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= COLLECT;
      data_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: collect bytes, hold a full block until it is taken
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
`ifdef UART_ASM_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      COLLECT: begin
        if (bus.rx_dv_i) begin
          data_d = shifted;
          if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_ASM_TIMEOUT_EN
        else if (expire) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
`endif
      end
      HOLD: begin
        if (bus.blk_ready_i) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          if (bus.rx_dv_i) begin
            data_d = shifted;
            cnt_d  = CNT_W'(1);
          end
        end else if (bus.rx_dv_i) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

`ifdef UART_ASM_TIMEOUT_EN
  // Idle counter: runs only while a partial block waits for more bytes
  always_comb begin
    idle_d = '0;
    if (state_q == COLLECT && !bus.rx_dv_i && cnt_q != '0 && !expire) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Idle counter and timeout pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.blk_valid_o = valid_q;
  assign bus.blk_data_o  = data_q;
  assign bus.byte_cnt_o  = cnt_q;
  assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_block_assembler.sv
// Self-checking bench for uart_block_assembler: directed scenarios plus a
// randomized phase, checked against a queue-of-bytes reference model.
// Completed blocks go into a scoreboard; a negedge monitor pops and compares
// on every handshake transfer.
module tb_uart_block_assembler;
  localparam int unsigned BB   = 16;
  localparam int unsigned DW   = 8 * BB;
  localparam int unsigned TMO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_block_assembler_if #(.BLOCK_BYTES(BB)) bus ();

  uart_block_assembler #(.BLOCK_BYTES(BB), .TIMEOUT_CLKS(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]    part[$];
  logic [DW-1:0] exp_q[$];
  logic          m_held = 1'b0;
  int            m_idle = 0;
  logic          m_ov   = 1'b0;
  logic          m_to   = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares the block on every valid&ready transfer
  always @(negedge clk) begin
    if (!rst && bus.blk_valid_o === 1'b1 && bus.blk_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", bus.blk_data_o, '0);
        if (bus.blk_data_o === '0) begin
          errors++;
          $display("FAIL unexpected_block actual=valid expected=no block @%0t", $time);
        end
      end else begin
        chk("block_data", bus.blk_data_o, exp_q.pop_front());
      end
    end
  end

  // One clock of reference behaviour for the inputs seen at this edge
  task automatic model(input logic dv, input logic [7:0] b, input logic rdy);
    logic [DW-1:0] blk;
    m_ov = 1'b0;
    m_to = 1'b0;
    if (m_held) begin
      m_idle = 0;
      if (rdy) begin
        m_held = 1'b0;
        if (dv) part.push_back(b);
      end else if (dv) begin
        m_ov = 1'b1;
      end
    end else if (dv) begin
      part.push_back(b);
      m_idle = 0;
      if (part.size() == BB) begin
        blk = '0;
        foreach (part[i]) blk[DW-1-8*i -: 8] = part[i];
        exp_q.push_back(blk);
        part.delete();
        m_held = 1'b1;
      end
    end else if (part.size() != 0) begin
`ifdef UART_ASM_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        part.delete();
        m_idle = 0;
        m_to   = 1'b1;
      end
`endif
    end
  endtask

  // Drive one cycle, advance the model, then check the registered outputs
  task automatic cyc(input logic dv, input logic [7:0] b, input logic rdy);
    int exp_cnt;
    bus.rx_dv_i     = dv;
    bus.rx_byte_i   = b;
    bus.blk_ready_i = rdy;
    @(posedge clk);
    model(dv, b, rdy);
    #1;
    exp_cnt = m_held ? 0 : part.size();
    chk("blk_valid", DW'(bus.blk_valid_o), DW'(m_held));
    chk("byte_cnt",  DW'(bus.byte_cnt_o),  DW'(exp_cnt));
    chk("overrun",   DW'(bus.overrun_o),   DW'(m_ov));
    chk("timeout",   DW'(bus.timeout_o),   DW'(m_to));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
  endtask

  task automatic send_seq(input logic [7:0] first, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'(first + 8'(i)), rdy);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", DW'(bus.blk_valid_o), '0);
    chk("rst_data",  bus.blk_data_o,       '0);
    chk("rst_cnt",   DW'(bus.byte_cnt_o),  '0);
    chk("rst_ovr",   DW'(bus.overrun_o),   '0);
    chk("rst_tmo",   DW'(bus.timeout_o),   '0);
    part.delete();
    exp_q.delete();
    m_held = 1'b0;
    m_idle = 0;
    m_ov   = 1'b0;
    m_to   = 1'b0;
    bus.rx_dv_i     = 1'b0;
    bus.blk_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [DW-1:0] t1_exp;

  initial begin
    bus.rx_dv_i     = 1'b0;
    bus.rx_byte_i   = 8'h00;
    bus.blk_ready_i = 1'b0;
    t1_exp = 128'h000102030405060708090A0B0C0D0E0F;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", DW'(bus.blk_valid_o), '0);
    chk("reset_data",  bus.blk_data_o,       '0);
    chk("reset_cnt",   DW'(bus.byte_cnt_o),  '0);
    rst = 1'b0;

    // 1: sixteen bytes with ready high -> single valid cycle
    send_seq(8'h00, BB, 1'b1);
    chk("t1_block_const", bus.blk_data_o, t1_exp);
    idle(3, 1'b1);

    // 2: stalled block, dropped byte, then release
    send_seq(8'h20, BB, 1'b0);
    idle(50, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    idle(3, 1'b0);

    // 3: transfer and new byte in the same cycle
    send_seq(8'h40, BB, 1'b0);
    idle(4, 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    send_seq(8'h61, BB - 1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);

    // 4: idle line with a partial block, then a clean block
    send_seq(8'hC0, 5, 1'b0);
`ifdef UART_ASM_TIMEOUT_EN
    idle(TMO + 5, 1'b0);
`else
    idle(10 * TMO, 1'b0);
`endif
    send_seq(8'h10, BB, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);

    // 5: byte strobe landing exactly on the expiry cycle
    send_seq(8'hD0, 5, 1'b0);
    idle(TMO - 1, 1'b0);
    cyc(1'b1, 8'hE5, 1'b0);
    idle(TMO + 2, 1'b0);

    // 6: reset mid-block and while holding, then a clean block
    send_seq(8'h80, 9, 1'b0);
    async_reset();
    send_seq(8'h90, BB, 1'b0);
    idle(2, 1'b0);
    async_reset();
    send_seq(8'hA0, BB, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic with idle gaps straddling the timeout length
    for (int ph = 0; ph < 40; ph++) begin
      for (int i = 0; i < 60; i++)
        cyc(1'(($urandom % 3) == 0), 8'($urandom), 1'(($urandom % 4) != 0 ? ($urandom % 2) : 0));
      idle(int'($urandom_range(TMO - 3, TMO + 3)), 1'(($urandom % 2)));
    end

    // Drain any held block and confirm the scoreboard emptied
    idle(4, 1'b1);
    chk("scoreboard_empty", DW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
